chess_display: RTL

Eight-digit multiplexed seven-segment driver for the chess timer on the Nexys 4. It consumes the 6-bit minute/second values of both players' countdown counters and shows them as MM.SS for player A on the left four digits and for player B on the right four. Inputs are snapshotted once per refresh frame so a digit never shows a half-updated time. A player whose time has reached 00:00 blinks.

---
 rtl/chess_display_if.sv | 23 ++
 rtl/chess_display.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/chess_display_if.sv
// rtl/chess_display_if.sv - time inputs and display outputs of the chess timer display
interface chess_display_if;
   logic [5:0] minA;
   logic [5:0] secA;
   logic [5:0] minB;
   logic [5:0] secB;
   logic       activeB;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   // The display driver consumes the times and drives the digit lines.
   modport slave (
      input  minA, secA, minB, secB, activeB,
      output an, seg, dp
   );

   // The timer core (or a bench) supplies the times and watches the digits.
   modport master (
      output minA, secA, minB, secB, activeB,
      input  an, seg, dp
   );
endinterface

// File: rtl/chess_display.sv
// rtl/chess_display.sv - eight-digit multiplexed MM.SS display for both chess players
module chess_display #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000
) (
   input  logic            clk,
   input  logic            rst,
   chess_display_if.slave  bus
);

   localparam int SW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [SW-1:0] presc;
   logic [2:0]    idx;
   logic [BW-1:0] bcnt;
   logic          phase;
   logic          load_pending;

   logic [5:0]    sA_min, sA_sec, sB_min, sB_sec;
   logic          sB_act;

   logic          scan_last;
   logic          frame_wrap;
   logic          load;
   logic          blink_last;

   logic [3:0]    digit;
   logic          a_expired, b_expired;
   logic          blank;
   logic [7:0]    an_next;
   logic [6:0]    seg_next;
   logic          dp_next;

   // Tens digit of a 0..63 value; 60..63 still yield 6 so they display as is.
   function automatic logic [3:0] bcd_tens(input logic [5:0] v);
      logic [3:0] t;
      if (v >= 6'd60)      t = 4'd6;
      else if (v >= 6'd50) t = 4'd5;
      else if (v >= 6'd40) t = 4'd4;
      else if (v >= 6'd30) t = 4'd3;
      else if (v >= 6'd20) t = 4'd2;
      else if (v >= 6'd10) t = 4'd1;
      else                 t = 4'd0;
      return t;
   endfunction

   function automatic logic [3:0] bcd_units(input logic [5:0] v);
      logic [5:0] tens10;
      logic [5:0] rem;
      tens10 = {2'b00, bcd_tens(v)} * 6'd10;
      rem    = v - tens10;
      return rem[3:0];
   endfunction

   // Active-low {g,f,e,d,c,b,a} patterns; non-decimal codes go dark.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign scan_last  = (presc == SW'(SCAN_DIV - 1));
   assign frame_wrap = scan_last && (idx == 3'd7);
   assign load       = load_pending || frame_wrap;
   assign blink_last = (bcnt == BW'(BLINK_DIV - 1));

   // Per-digit prescaler and digit index; the index advances once per SCAN_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= 3'd0;
      end else begin
         if (scan_last) begin
            presc <= '0;
            idx   <= idx + 3'd1;
         end else begin
            presc <= presc + SW'(1);
         end
      end
   end

   // Free-running blink timebase, unrelated to the scan so blink rate is exact.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else begin
         if (blink_last) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt  <= bcnt + BW'(1);
         end
      end
   end

   // Snapshot the times once per frame (and once right after reset) so no frame mixes old and new.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sA_min       <= 6'd0;
         sA_sec       <= 6'd0;
         sB_min       <= 6'd0;
         sB_sec       <= 6'd0;
         sB_act       <= 1'b0;
         load_pending <= 1'b1;
      end else begin
         if (load) begin
            sA_min       <= bus.minA;
            sA_sec       <= bus.secA;
            sB_min       <= bus.minB;
            sB_sec       <= bus.secB;
            sB_act       <= bus.activeB;
            load_pending <= 1'b0;
         end
      end
   end

   // Select the digit value, blanking and decimal point for the current index.
   always_comb begin
      digit     = 4'd0;
      a_expired = (sA_min == 6'd0) && (sA_sec == 6'd0);
      b_expired = (sB_min == 6'd0) && (sB_sec == 6'd0);
      case (idx)
         3'd7:    digit = bcd_tens(sA_min);
         3'd6:    digit = bcd_units(sA_min);
         3'd5:    digit = bcd_tens(sA_sec);
         3'd4:    digit = bcd_units(sA_sec);
         3'd3:    digit = bcd_tens(sB_min);
         3'd2:    digit = bcd_units(sB_min);
         3'd1:    digit = bcd_tens(sB_sec);
         default: digit = bcd_units(sB_sec);
      endcase
      // idx[2] set means the left half, i.e. player A.
      blank    = phase && (idx[2] ? a_expired : b_expired);
      an_next  = blank ? 8'hFF : ~(8'h01 << idx);
      seg_next = seg7(digit);
      dp_next  = !((idx == 3'd6) || (idx == 3'd2) ||
                   ((idx == 3'd4) && !sB_act) ||
                   ((idx == 3'd0) &&  sB_act));
   end

   // Registered pin drivers, one cycle behind the index/snapshot/phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.an  <= 8'hFF;
         bus.seg <= 7'h7F;
         bus.dp  <= 1'b1;
      end else begin
         bus.an  <= an_next;
         bus.seg <= seg_next;
         bus.dp  <= dp_next;
      end
   end

endmodule
